// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the OAM DMA master.
package oam_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    GAP,
    DONE,
    WAIT_GNT
  } dma_state_e;

  localparam logic [15:0] DMA_TRIG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE      = 16'hFE00;
  localparam int          DEF_NUM_BYTES = 160;
  localparam logic [7:0]  ECHO_THRESH   = 8'hE0;

  // Pages E0..FF mirror C0..DF (echo RAM).
  function automatic logic [7:0] remap_page(input logic [7:0] p);
    return (p >= ECHO_THRESH) ? p - 8'h20 : p;
  endfunction

endpackage

// File: rtl/oam_dma_master_if.sv
// mem_if: byte-wide memory bus shared by initiators and MMIO/RAM responders.
interface mem_if;
  logic [15:0] addr_select;
  logic [7:0]  write_value;
  logic        write_enable;
  logic [7:0]  read_out;

  modport master (output addr_select, output write_value, output write_enable, input read_out);
  modport slave  (input addr_select, input write_value, input write_enable, output read_out);
endinterface

// File: rtl/oam_dma_master.sv
// OAM DMA master: copies NUM_BYTES from {page,00} to DST_BASE, one read + one write per byte.
// Optional bus arbitration (bus_req/bus_gnt) is enabled by defining OAM_DMA_BUS_ARB_EN.
module oam_dma_master
  import oam_dma_pkg::*;
#(
  parameter int          NUM_BYTES = DEF_NUM_BYTES,
  parameter logic [15:0] DST_BASE  = OAM_BASE,
  parameter int          READ_WAIT = 1,
  parameter int          WE_HOLD   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] src_page,
  mem_if.master      bus,
  output logic       busy,
  output logic       done,
  output logic [7:0] byte_idx
`ifdef OAM_DMA_BUS_ARB_EN
  ,
  output logic       bus_req,
  input  logic       bus_gnt
`endif
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);
  localparam logic [7:0] RD_LAST  = 8'(READ_WAIT - 1);
  localparam logic [7:0] WR_LAST  = 8'(WE_HOLD - 1);

  dma_state_e  state;
  logic [7:0]  page;
  logic [7:0]  phase;
  logic        restart;
  logic [15:0] addr_q;
  logic [7:0]  wval_q;
  logic        we_q;
  logic [7:0]  nxt_idx;

  assign bus.addr_select  = addr_q;
  assign bus.write_value  = wval_q;
  assign bus.write_enable = we_q;

  // After an aborted transfer the GAP cycle restarts from byte 0.
  always_comb begin
    nxt_idx = restart ? 8'h00 : byte_idx + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      page     <= '0;
      phase    <= '0;
      restart  <= 1'b0;
      addr_q   <= '0;
      wval_q   <= '0;
      we_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_idx <= '0;
`ifdef OAM_DMA_BUS_ARB_EN
      bus_req  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (start && (state == IDLE || state == DONE)) begin
        page     <= remap_page(src_page);
        byte_idx <= '0;
        phase    <= '0;
        restart  <= 1'b0;
        busy     <= 1'b1;
`ifdef OAM_DMA_BUS_ARB_EN
        bus_req  <= 1'b1;
        state    <= WAIT_GNT;
`else
        state    <= RD;
        addr_q   <= {remap_page(src_page), 8'h00};
`endif
      end else if (start) begin
        // Restart: drop the bus for one GAP cycle, then begin again on the new page.
        page    <= remap_page(src_page);
        restart <= 1'b1;
        phase   <= '0;
        we_q    <= 1'b0;
        addr_q  <= '0;
        wval_q  <= '0;
        state   <= GAP;
      end else begin
        unique case (state)
          IDLE: ;
`ifdef OAM_DMA_BUS_ARB_EN
          WAIT_GNT: if (bus_gnt) begin
            state  <= RD;
            addr_q <= {page, byte_idx};
          end
`endif
          RD: begin
            if (phase == RD_LAST) begin
              phase  <= '0;
              wval_q <= bus.read_out;
              addr_q <= DST_BASE + {8'h00, byte_idx};
              we_q   <= 1'b1;
              state  <= WR;
            end else begin
              phase <= phase + 8'd1;
            end
          end
          WR: begin
            if (phase == WR_LAST) begin
              phase  <= '0;
              we_q   <= 1'b0;
              addr_q <= '0;
              wval_q <= '0;
              state  <= GAP;
            end else begin
              phase <= phase + 8'd1;
            end
          end
          GAP: begin
            if (!restart && byte_idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
`ifdef OAM_DMA_BUS_ARB_EN
              bus_req <= 1'b0;
`endif
            end else begin
              byte_idx <= nxt_idx;
              restart  <= 1'b0;
`ifdef OAM_DMA_BUS_ARB_EN
              if (bus_gnt) begin
                state  <= RD;
                addr_q <= {page, nxt_idx};
              end else begin
                state <= WAIT_GNT;
              end
`else
              state  <= RD;
              addr_q <= {page, nxt_idx};
`endif
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma_master.sv
// Directed bench for oam_dma_master (default build): copy, echo remap, restart, async reset.
module tb_oam_dma_master;
  import oam_dma_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] src_page = 8'h00;
  logic       busy, done;
  logic [7:0] byte_idx;

  mem_if bus ();

  // Source memory: every byte reads as its low address ^ 5A.
  assign bus.read_out = bus.addr_select[7:0] ^ 8'h5A;

  oam_dma_master dut (
    .clk(clk), .rst(rst), .start(start), .src_page(src_page), .bus(bus),
    .busy(busy), .done(done), .byte_idx(byte_idx)
  );

  always #5 clk = ~clk;

  int vecs = 0, miss = 0;
  int cyc = 0, e0 = 0;
  always @(posedge clk) cyc++;

  // Bus monitor: logs completed writes and read addresses.
  logic [15:0] wr_a [256];
  logic [7:0]  wr_d [256];
  int          wr_len [256];
  logic [15:0] rd_a [256];
  int n_wr, n_rd, run, unstable, busy_cnt, done_cnt, done_cyc;
  logic [15:0] cur_a;
  logic [7:0]  cur_d;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (bus.write_enable) begin
      if (run == 0) begin cur_a = bus.addr_select; cur_d = bus.write_value; end
      else if (bus.addr_select != cur_a || bus.write_value != cur_d) unstable++;
      run++;
    end else begin
      if (run != 0) begin
        if (n_wr < 256) begin wr_a[n_wr] = cur_a; wr_d[n_wr] = cur_d; wr_len[n_wr] = run; end
        n_wr++;
        run = 0;
      end
      if (bus.addr_select != 16'h0000) begin
        if (n_rd < 256) rd_a[n_rd] = bus.addr_select;
        n_rd++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_wr = 0; n_rd = 0; run = 0; unstable = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0;
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic do_start(input logic [7:0] p);
    start = 1'b1; src_page = p;
    @(posedge clk); #1;
    e0 = cyc; start = 1'b0;
    clr();
    step();
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && !done; i++) step();
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic chk_xfer(input logic [15:0] rd_base);
    chk("n_writes", n_wr, 160);
    chk("n_reads", n_rd, 160);
    chk("we_unstable", unstable, 0);
    for (int i = 0; i < 160 && i < n_wr; i++) begin
      chk("wr_addr", {16'd0, wr_a[i]}, 32'hFE00 + i);
      chk("wr_data", {24'd0, wr_d[i]}, {24'd0, 8'(i) ^ 8'h5A});
      chk("we_len", wr_len[i], 2);
    end
    for (int i = 0; i < 160 && i < n_rd; i++)
      chk("rd_addr", {16'd0, rd_a[i]}, {16'd0, rd_base} + i);
  endtask

  initial begin
    clr();
    // Reset state
    step();
    chk("rst_addr", {16'd0, bus.addr_select}, 0);
    chk("rst_we", {31'd0, bus.write_enable}, 0);
    chk("rst_wval", {24'd0, bus.write_value}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_idx", {24'd0, byte_idx}, 0);
    rst = 1'b1;
    step(); step();

    // T1: plain copy from C100
    do_start(8'hC1);
    chk("t1_first_rd", {16'd0, bus.addr_select}, 32'hC100);
    chk("t1_busy", {31'd0, busy}, 1);
    wait_done(1000);
    chk("t1_latency", done_cyc - e0, 640);
    chk("t1_busy_cycles", busy_cnt, 640);
    chk("t1_done_busy", {31'd0, busy}, 0);
    chk("t1_done_cnt", done_cnt, 1);
    chk_xfer(16'hC100);

    // T2: start during the DONE cycle, echo page E3 -> C3
    do_start(8'hE3);
    chk("t2_first_rd", {16'd0, bus.addr_select}, 32'hC300);
    chk("t2_idx", {24'd0, byte_idx}, 0);
    wait_done(1000);
    chk("t2_latency", done_cyc - e0, 640);
    chk_xfer(16'hC300);
    step(); step(); step();
    chk("t2_idle_busy", {31'd0, busy}, 0);
    chk("t2_idle_addr", {16'd0, bus.addr_select}, 0);
    chk("t2_done_cnt", done_cnt, 1);

    // T3: restart while writing byte 40
    do_start(8'hC1);
    for (int i = 0; i < 1000 && !(byte_idx == 8'd40 && bus.write_enable); i++) step();
    chk("t3_reach_40", {31'd0, bus.write_enable}, 1);
    chk("t3_idx40", {24'd0, byte_idx}, 40);
    do_start(8'hC2);
    chk("t3_gap_we", {31'd0, bus.write_enable}, 0);
    chk("t3_gap_addr", {16'd0, bus.addr_select}, 0);
    chk("t3_gap_busy", {31'd0, busy}, 1);
    clr();
    step();
    chk("t3_rd_addr", {16'd0, bus.addr_select}, 32'hC200);
    chk("t3_rd_idx", {24'd0, byte_idx}, 0);
    wait_done(1000);
    chk("t3_latency", done_cyc - e0, 641);
    chk_xfer(16'hC200);
    step(); step();
    chk("t3_done_cnt", done_cnt, 1);

    // T4: asynchronous reset at byte 100
    do_start(8'hC1);
    for (int i = 0; i < 1000 && byte_idx != 8'd100; i++) step();
    chk("t4_reach_100", {24'd0, byte_idx}, 100);
    #2 rst = 1'b0;
    #1;
    chk("t4_addr", {16'd0, bus.addr_select}, 0);
    chk("t4_we", {31'd0, bus.write_enable}, 0);
    chk("t4_wval", {24'd0, bus.write_value}, 0);
    chk("t4_busy", {31'd0, busy}, 0);
    chk("t4_idx", {24'd0, byte_idx}, 0);
    clr();
    step(); step();
    rst = 1'b1;
    repeat (40) step();
    chk("t4_no_writes", n_wr, 0);
    chk("t4_no_reads", n_rd, 0);
    chk("t4_no_busy", busy_cnt, 0);
    chk("t4_no_done", done_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
